// File: rtl/param_ser.sv
// Parallel-to-serial feeder: one W-bit word per handshake, one bit every DIV clocks on x,
// framed by y, followed by one idle bit-period before the next word is accepted.
module param_ser #(
  parameter int W         = 8,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         y,
  output logic         busy,
  output logic         done
);

  localparam int BW   = $clog2(W + 1);
  localparam int DW   = $clog2(DIV + 1);
  localparam int HEAD = LSB_FIRST ? 0 : W - 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(W);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_reg;
  logic [W-1:0]  sr_reg;
  logic [DW-1:0] div_reg;
  logic [BW-1:0] bit_reg;
  logic          din_ready_reg;
  logic          x_reg;
  logic          y_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [W-1:0]  sr_shift;
  logic [W-1:0]  din_shift;
  logic          div_wrap;

  // The current bit lives in x_reg; sr_reg holds only the bits still to be sent,
  // so capture stores din already advanced by one place toward the head.
  for (genvar gi = 0; gi < W; gi++) begin : g_shift
    if (LSB_FIRST) begin : g_down
      if (gi == W - 1) begin : g_fill
        assign sr_shift[gi]  = 1'b0;
        assign din_shift[gi] = 1'b0;
      end else begin : g_move
        assign sr_shift[gi]  = sr_reg[gi+1];
        assign din_shift[gi] = din[gi+1];
      end
    end else begin : g_up
      if (gi == 0) begin : g_fill
        assign sr_shift[gi]  = 1'b0;
        assign din_shift[gi] = 1'b0;
      end else begin : g_move
        assign sr_shift[gi]  = sr_reg[gi-1];
        assign din_shift[gi] = din[gi-1];
      end
    end
  end

  assign div_wrap = (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      div_reg       <= '0;
      bit_reg       <= '0;
      din_ready_reg <= 1'b1;
      x_reg         <= 1'b0;
      y_reg         <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (din_valid && din_ready_reg) begin
            sr_reg        <= din_shift;
            div_reg       <= '0;
            bit_reg       <= BIT_LOAD;
            x_reg         <= din[HEAD];
            y_reg         <= 1'b1;
            busy_reg      <= 1'b1;
            din_ready_reg <= 1'b0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_reg <= '0;
            sr_reg  <= sr_shift;
            bit_reg <= bit_reg - BIT_ONE;
            if (bit_reg == BIT_ONE) begin
              x_reg     <= 1'b0;
              y_reg     <= 1'b0;
              state_reg <= GAP;
            end else begin
              x_reg <= sr_reg[HEAD];
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        GAP: begin
          if (div_wrap) begin
            div_reg       <= '0;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            din_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign din_ready = din_ready_reg;
  assign x         = x_reg;
  assign y         = y_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_param_ser.sv
// Scoreboard bench for param_ser: three parameterisations, stimulus pushes expected frames,
// per-instance monitors pop and check each serialised frame.
module tb_param_ser;

  localparam int NI = 3;

  function automatic int p_w(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int p_d(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 256;
    endcase
  endfunction

  function automatic int p_l(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] bits;    // bit k = k-th bit expected on x
    int          ylen;
    int          done_o;  // monitor sample index where done and din_ready must be high
    int          gap;     // required handshake spacing, 0 = not checked
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI-1:0]   valid_v = '0;
  logic [NI-1:0]   ready_v;
  logic [NI-1:0]   x_v;
  logic [NI-1:0]   y_v;
  logic [NI-1:0]   busy_v;
  logic [NI-1:0]   done_v;
  logic [31:0]     din_a [NI];

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int GW = p_w(gi);
    localparam int GD = p_d(gi);
    localparam int GL = p_l(gi);

    param_ser #(.W(GW), .DIV(GD), .LSB_FIRST(GL[0])) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din_a[gi][GW-1:0]),
      .din_valid (valid_v[gi]),
      .din_ready (ready_v[gi]),
      .x         (x_v[gi]),
      .y         (y_v[gi]),
      .busy      (busy_v[gi]),
      .done      (done_v[gi])
    );

    logic rst_s = 1'b0;
    logic hs_s  = 1'b0;
    always @(posedge clk) begin
      rst_s <= rst;
      hs_s  <= valid_v[gi] & ready_v[gi] & ~rst;
    end

    initial begin
      exp_t        e;
      bit          active;
      int          o, kk, ycnt, dcnt, ctl, glitch, cyc, last_hs;
      logic [31:0] cap;
      active = 0; cyc = 0; last_hs = -100000;
      o = 0; ycnt = 0; dcnt = 0; ctl = 0; glitch = 0; cap = '0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_s) begin
          active = 0;
          chk("reset_outputs", gi, {ready_v[gi], x_v[gi], y_v[gi], busy_v[gi], done_v[gi]}, 5'b10000);
        end else begin
          if (hs_s) begin
            if (sb_q.size() == 0 || sb_q[0].inst != gi) begin
              chk("unexpected_handshake", gi, 1, 0);
              active = 0;
            end else begin
              e = sb_q.pop_front();
              if (e.gap != 0) chk("handshake_spacing", gi, cyc - last_hs, e.gap);
              active = 1; o = 0; cap = '0; glitch = 0; ctl = 0; ycnt = 0; dcnt = 0;
            end
            last_hs = cyc;
          end
          if (active) begin
            o++;
            if (o <= GW * GD) begin
              kk = (o - 1) / GD;
              if ((o - 1) % GD == 0) cap[kk] = x_v[gi];
              else if (x_v[gi] !== cap[kk]) glitch++;
              if (y_v[gi] !== 1'b1) ctl++;
            end else if (x_v[gi] !== 1'b0 || y_v[gi] !== 1'b0) begin
              ctl++;
            end
            if (y_v[gi] === 1'b1) ycnt++;
            if (done_v[gi] === 1'b1) dcnt++;
            if (o < e.done_o && (ready_v[gi] !== 1'b0 || busy_v[gi] !== 1'b1 || done_v[gi] !== 1'b0)) ctl++;
            if (o == e.done_o) begin
              chk("x_bits", gi, int'(cap), int'(e.bits));
              chk("bit_hold", gi, glitch, 0);
              chk("frame_ctl", gi, ctl, 0);
              chk("y_length", gi, ycnt, e.ylen);
              chk("done_at_end", gi, int'(done_v[gi]), 1);
              chk("done_count", gi, dcnt, 1);
              chk("ready_back", gi, int'(ready_v[gi]), 1);
              chk("busy_clear", gi, int'(busy_v[gi]), 0);
              $display("frame inst%0d bits=%h ylen=%0d done_at=%0d", gi, cap, ycnt, o);
              active = 0;
            end
          end else begin
            chk("idle_outputs", gi, {ready_v[gi], x_v[gi], y_v[gi], busy_v[gi], done_v[gi]}, 5'b10000);
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [31:0] b, input int yl, input int dn, input int gp);
    exp_t e;
    e.inst = i; e.bits = b; e.ylen = yl; e.done_o = dn; e.gap = gp;
    sb_q.push_back(e);
  endtask

  task automatic send(input int i, input logic [31:0] d, input bit hold);
    int n = 0;
    din_a[i]   = d;
    valid_v[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (ready_v[i] !== 1'b1 && n < 2000);
    if (ready_v[i] !== 1'b1) begin
      checks++; failures++;
      $display("FAIL handshake_timeout inst%0d: din_ready low for %0d cycles", i, n);
    end
    @(posedge clk); #1;
    if (!hold) valid_v[i] = 1'b0;
    din_a[i] = $urandom;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while ((sb_q.size() != 0 || busy_v[i] !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL frame_timeout inst%0d: still busy after %0d cycles", i, n);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) din_a[i] = '0;
    valid_v[0] = 1'b1;
    din_a[0]   = 32'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    push(0, 32'hA5, 32, 37, 0); send(0, 32'hA5, 0); wait_done(0);
    push(0, 32'h13, 32, 37, 0); send(0, 32'hC8, 0); wait_done(0);

    push(1, 32'h3, 4, 6, 0); send(1, 32'h3, 0); wait_done(1);
    push(1, 32'h6, 4, 6, 0); send(1, 32'h6, 0); wait_done(1);

    // din_valid held high across two words, din scrambled while the first shifts
    push(0, 32'h80, 32, 37, 0);
    push(0, 32'h01, 32, 37, 37);
    send(0, 32'h01, 1);
    repeat (10) @(posedge clk);
    #1;
    send(0, 32'h80, 0);
    wait_done(0);

    // reset lands on the 10th SHIFT clock; the word is dropped and no done follows
    push(0, 32'hE7, 32, 37, 0);
    send(0, 32'hE7, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push(0, 32'h3C, 32, 37, 0); send(0, 32'h3C, 0); wait_done(0);

    // reset coinciding with a handshake must not capture the word
    valid_v[0] = 1'b1;
    din_a[0]   = 32'h55;
    rst        = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    valid_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    push(2, 32'h1, 256, 513, 0); send(2, 32'h1, 0); wait_done(2);
    push(2, 32'h0, 256, 513, 0); send(2, 32'h0, 0); wait_done(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_ser.md
# param_ser

Parameterised parallel-to-serial feeder that drives the two-wire `x`/`y` input pair of the parameterised receive stage downstream of it. It accepts one `W`-bit word per valid/ready handshake and shifts it out one bit per `DIV` clocks on `x`. It holds frame strobe `y` high for the whole data phase, then inserts one idle bit-period gap before accepting the next word. It sits between the register front-end and that receive stage.

## Interface
- `W`, default 8: word width in bits; legal range 1..32.
- `DIV`, default 4: clocks per serial bit; legal range 1..256.
- `LSB_FIRST`, default 0: 1 = bit 0 sent first; 0 = bit `W-1` sent first.
- localparam `BW` = `$clog2(W+1)`: bit-counter width.
- localparam `DW` = `$clog2(DIV+1)`: divider-counter width.

- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `din`  input  `W`: parallel word; sampled only on handshake.
- `din_valid`  input  1: upstream has a word.
- `din_ready`  output  1: block can accept a word.
- `x`  output  1: serial data bit, registered.
- `y`  output  1: frame strobe, registered; high for exactly `W*DIV` clocks per word.
- `busy`  output  1: high in SHIFT and GAP.
- `done`  output  1: one-clock pulse on the last clock of GAP.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE
  - `din_ready`=1, `x`=0, `y`=0.
  - On `din_valid & din_ready`: capture `din` into the shift register, clear the divider, load bit count = `W`, go to SHIFT.
- SHIFT
  - `y`=1.
  - `x` = current head bit: `sr[W-1]` if `LSB_FIRST`=0, else `sr[0]`.
  - Divider counts 0..`DIV-1`. On wrap, shift one place toward the head and decrement the bit count.
  - When the count reaches 0 on a wrap, go to GAP.
- GAP
  - `x`=0, `y`=0 for `DIV` clocks.
  - `done`=1 on the final GAP clock, then go to IDLE.
- `din_ready` is 0 in SHIFT and GAP. `din_valid` there is ignored, and `din` may change freely.
- `busy` = (state != IDLE).
- Shift register fill bits are 0. Bits shifted out are discarded.
- `DIV`=1: one bit per clock; GAP lasts one clock.
- `W`=1: SHIFT lasts exactly `DIV` clocks.
- Reset values, all outputs: `din_ready`=1, `x`=0, `y`=0, `busy`=0, `done`=0. State=IDLE; counters and shift register cleared.
- Reset mid-operation: the word is aborted and no `done` is issued. Reset values appear the clock after `rst` is sampled high. `rst` wins over a simultaneous handshake, and the word is not captured.

## Timing
- Handshake sampled at edge T.
- From edge T+1:
  - `y`=1 and `x` = first bit.
  - Each bit is held for `DIV` clocks.
  - Bit k is valid for edges T+1+k*`DIV` .. T+(k+1)*`DIV`.
- `y` falls at edge T+1+`W*DIV`.
- `done` is high for the cycle after edge T+`(W+1)*DIV`.
- `din_ready` returns high at edge T+1+`(W+1)*DIV`.
- Minimum handshake-to-handshake spacing: `(W+1)*DIV+1` clocks.
- Throughput: one word per `(W+1)*DIV+1` clocks.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst` 3 clocks with `din_valid`=1, `din`=8'hFF. Required: `din_ready`=1 and `x`=`y`=`busy`=`done`=0 throughout; no capture after release until a fresh handshake.
- Default params, MSB first: `din`=8'hA5 handshaked at T.
  - `x` sequence is 1,0,1,0,0,1,0,1, each bit 4 clocks.
  - `y` high for 32 clocks.
  - `done` in the cycle after edge T+36.
  - `din_ready` high at edge T+37.
- `LSB_FIRST`=1, `W`=4, `DIV`=1: `din`=4'b0011. Required: `x` = 1,1,0,0 on consecutive clocks; `y` high 4 clocks; GAP 1 clock.
- Back-to-back: hold `din_valid`=1 with 8'h01 then 8'h80. Required: the second handshake is exactly 37 clocks after the first, and `din` changes during SHIFT do not corrupt the first word.
- Mid-word reset: assert `rst` on the 10th SHIFT clock. Required: outputs return to reset values the following clock; `done` never pulses; the next word (8'h3C) serialises correctly.
- `W`=1, `DIV`=256: `din`=1. Required: `y` and `x` high for exactly 256 clocks; `done` after 512 clocks; no divider-counter overflow.
